// File: rtl/fifo_pkg.sv
// Shared FIFO constants and the width helper used for pointer and count sizing.
package fifo_pkg;
    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // ceil(log2(v)); callers guarantee v >= 2 so the result is at least 1
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/fifo_syn_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read. Contents are never reset.
module fifo_syn_mem #(
    parameter int DEPTH = 16,
    parameter int DWTH  = 8,
    parameter int AW    = 4
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [DWTH-1:0] wdata_i,
    input  logic [AW-1:0]   raddr_i,
    output logic [DWTH-1:0] rdata_o
);
    logic [DWTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/fifo_syn_fwft.sv
// Synchronous FIFO with selectable standard (registered) or first-word-fall-through read,
// arbitrary depth, and full/empty/almost/programmable status flags.
module fifo_syn_fwft
    import fifo_pkg::*;
#(
    parameter int FIFO_DEPTH        = 16,
    parameter int FIFO_DWTH         = 8,
    parameter int FWFT_MODE         = 0,
    parameter int PROG_FULL_THRESH  = FIFO_DEPTH - 2,
    parameter int PROG_EMPTY_THRESH = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [FIFO_DWTH-1:0]               din,
    input  logic                               wren,
    input  logic                               rden,
    output logic [FIFO_DWTH-1:0]               dout,
    output logic                               valid,
    output logic                               full,
    output logic                               empty,
    output logic                               almost_full,
    output logic                               almost_empty,
    output logic                               prog_full,
    output logic                               prog_empty,
    output logic [clog2(FIFO_DEPTH+1)-1:0]     data_count,
    output logic                               overflow,
    output logic                               underflow
);
    localparam int PW    = clog2(FIFO_DEPTH);
    localparam int CNT_W = clog2(FIFO_DEPTH + 1);

    if (FIFO_DEPTH < 2 || FIFO_DWTH < 1 ||
        (FWFT_MODE != FIFO_MODE_STD && FWFT_MODE != FIFO_MODE_FWFT) ||
        PROG_FULL_THRESH < 1 || PROG_FULL_THRESH > FIFO_DEPTH ||
        PROG_EMPTY_THRESH < 0 || PROG_EMPTY_THRESH > FIFO_DEPTH - 1) begin : g_bad_param
        $error("fifo_syn_fwft: illegal parameter value");
    end

    logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, raddr;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [FIFO_DWTH-1:0] dout_q, dout_d, mem_rdata;
    logic                 valid_q, valid_d, ovf_q, unf_q;
    logic                 wr_acc, rd_acc, is_full, is_empty;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // In FWFT mode valid tracks count != 0, so !valid is equivalent to an empty count.
    assign is_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign is_empty = (FWFT_MODE == FIFO_MODE_FWFT) ? !valid_q : (count_q == '0);
    assign wr_acc   = wren && !is_full;
    assign rd_acc   = rden && !is_empty;

    always_comb begin
        wr_ptr_d = wr_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = rd_acc ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (wr_acc && !rd_acc)      count_d = count_q + 1'b1;
        else if (rd_acc && !wr_acc) count_d = count_q - 1'b1;

        dout_d = dout_q;
        if (FWFT_MODE == FIFO_MODE_FWFT) begin
            // Look ahead to the word presented after this edge; bypass din when it lands there now.
            raddr   = rd_ptr_d;
            valid_d = (count_d != '0);
            if (count_d != '0)
                dout_d = (wr_acc && wr_ptr_q == rd_ptr_d) ? din : mem_rdata;
        end else begin
            raddr   = rd_ptr_q;
            valid_d = rd_acc;
            if (rd_acc) dout_d = mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            ovf_q    <= wren && is_full;
            unf_q    <= rden && is_empty;
        end
    end

    fifo_syn_mem #(
        .DEPTH (FIFO_DEPTH),
        .DWTH  (FIFO_DWTH),
        .AW    (PW)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (din),
        .raddr_i (raddr),
        .rdata_o (mem_rdata)
    );

    assign dout         = dout_q;
    assign valid        = valid_q;
    assign full         = is_full;
    assign empty        = is_empty;
    assign almost_full  = (count_q >= CNT_W'(FIFO_DEPTH - 1));
    assign almost_empty = (count_q <= CNT_W'(1));
    assign prog_full    = (count_q >= CNT_W'(PROG_FULL_THRESH));
    assign prog_empty   = (count_q <= CNT_W'(PROG_EMPTY_THRESH));
    assign data_count   = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
endmodule

// File: tb/tb_fifo_syn_fwft.sv
// Directed bench: standard-read depth 16, FWFT depth 16, and standard-read depth 5 instances.
module tb_fifo_syn_fwft;
    logic clk, rst_n;
    int total, bad;

    logic [7:0] d0, q0, d1, q1, d5, q5;
    logic       w0, r0, v0, full0, emp0, af0, ae0, pf0, pe0, ov0, un0;
    logic       w1, r1, v1, full1, emp1, af1, ae1, pf1, pe1, ov1, un1;
    logic       w5, r5, v5, full5, emp5, af5, ae5, pf5, pe5, ov5, un5;
    logic [4:0] cnt0, cnt1;
    logic [2:0] cnt5;

    fifo_syn_fwft #(.FIFO_DEPTH(16), .FIFO_DWTH(8), .FWFT_MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .din(d0), .wren(w0), .rden(r0), .dout(q0), .valid(v0),
        .full(full0), .empty(emp0), .almost_full(af0), .almost_empty(ae0), .prog_full(pf0),
        .prog_empty(pe0), .data_count(cnt0), .overflow(ov0), .underflow(un0));

    fifo_syn_fwft #(.FIFO_DEPTH(16), .FIFO_DWTH(8), .FWFT_MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .din(d1), .wren(w1), .rden(r1), .dout(q1), .valid(v1),
        .full(full1), .empty(emp1), .almost_full(af1), .almost_empty(ae1), .prog_full(pf1),
        .prog_empty(pe1), .data_count(cnt1), .overflow(ov1), .underflow(un1));

    fifo_syn_fwft #(.FIFO_DEPTH(5), .FIFO_DWTH(8), .FWFT_MODE(0), .PROG_FULL_THRESH(3)) u5 (
        .clk(clk), .rst_n(rst_n), .din(d5), .wren(w5), .rden(r5), .dout(q5), .valid(v5),
        .full(full5), .empty(emp5), .almost_full(af5), .almost_empty(ae5), .prog_full(pf5),
        .prog_empty(pe5), .data_count(cnt5), .overflow(ov5), .underflow(un5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp5 [5];
        exp5[0] = 8'h18; exp5[1] = 8'h19; exp5[2] = 8'h1A; exp5[3] = 8'h1B; exp5[4] = 8'h20;
        total = 0; bad = 0;
        {w0, r0, w1, r1, w5, r5} = '0;
        d0 = '0; d1 = '0; d5 = '0;
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        chk("rst_empty", emp0, 1); chk("rst_full", full0, 0); chk("rst_pe", pe0, 1);
        chk("rst_cnt", cnt0, 0); chk("rst_valid", v0, 0); chk("rst_dout", q0, 0);
        chk("rst_ovf", ov0, 0); chk("rst_unf", un0, 0);
        chk("rst_fwft_valid", v1, 0); chk("rst_fwft_empty", emp1, 1);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

        // standard mode fill to full, then overflow
        w0 = 1;
        for (int i = 0; i < 16; i++) begin
            d0 = 8'(i);
            tick();
            chk($sformatf("fill_cnt%0d", i), cnt0, i + 1);
            if (i == 14) begin
                chk("cnt15_full", full0, 0); chk("cnt15_af", af0, 1);
            end
        end
        chk("fill_full", full0, 1); chk("fill_af", af0, 1); chk("fill_pf", pf0, 1);
        chk("fill_empty", emp0, 0);
        d0 = 8'hFF; tick();
        chk("ovf_pulse", ov0, 1); chk("ovf_cnt", cnt0, 16);
        w0 = 0; tick();
        chk("ovf_clear", ov0, 0);

        // drain in order, then underflow
        r0 = 1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk($sformatf("drain_v%0d", i), v0, 1);
            chk($sformatf("drain_d%0d", i), q0, i);
            chk($sformatf("drain_c%0d", i), cnt0, 15 - i);
        end
        r0 = 0; tick();
        chk("drain_vlow", v0, 0); chk("drain_hold", q0, 8'h0F);
        chk("drain_empty", emp0, 1); chk("drain_pe", pe0, 1);
        r0 = 1; tick();
        chk("unf_pulse", un0, 1); chk("unf_valid", v0, 0);
        r0 = 0; tick();
        chk("unf_clear", un0, 0);

        // simultaneous read/write at empty and at full
        w0 = 1; r0 = 1; d0 = 8'h55; tick();
        chk("both_empty_cnt", cnt0, 1); chk("both_empty_unf", un0, 1); chk("both_empty_v", v0, 0);
        r0 = 0;
        for (int i = 0; i < 15; i++) begin
            d0 = 8'(8'h60 + i);
            tick();
        end
        chk("refill_cnt", cnt0, 16);
        d0 = 8'hEE; r0 = 1; tick();
        chk("both_full_cnt", cnt0, 15); chk("both_full_ovf", ov0, 1);
        chk("both_full_v", v0, 1); chk("both_full_d", q0, 8'h55);
        w0 = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk($sformatf("drop_d%0d", i), q0, 8'h60 + i);
        end
        chk("drop_cnt", cnt0, 0); chk("drop_empty", emp0, 1);
        r0 = 0; tick();

        // depth 5: wrap with interleaved traffic
        w5 = 1;
        for (int i = 0; i < 4; i++) begin
            d5 = 8'(8'h10 + i);
            tick();
        end
        chk("d5_cnt4", cnt5, 4); chk("d5_pf", pf5, 1); chk("d5_af", af5, 1);
        r5 = 1;
        for (int k = 0; k < 8; k++) begin
            d5 = 8'(8'h14 + k);
            tick();
            chk($sformatf("d5_il_d%0d", k), q5, 8'h10 + k);
            chk($sformatf("d5_il_c%0d", k), cnt5, 4);
        end
        r5 = 0; d5 = 8'h20; tick();
        chk("d5_full_cnt", cnt5, 5); chk("d5_full", full5, 1);
        d5 = 8'h21; tick();
        chk("d5_ovf", ov5, 1); chk("d5_ovf_cnt", cnt5, 5);
        w5 = 0; r5 = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("d5_rd%0d", i), q5, exp5[i]);
        end
        r5 = 0; tick();
        chk("d5_empty", emp5, 1); chk("d5_ae", ae5, 1);

        // FWFT presentation
        w1 = 1; d1 = 8'hA5; tick(); w1 = 0;
        chk("fw_v", v1, 1); chk("fw_d", q1, 8'hA5); chk("fw_empty", emp1, 0); chk("fw_cnt", cnt1, 1);
        r1 = 1; tick(); r1 = 0;
        chk("fw_pop_v", v1, 0); chk("fw_pop_empty", emp1, 1); chk("fw_pop_cnt", cnt1, 0);
        r1 = 1; tick(); r1 = 0;
        chk("fw_unf", un1, 1);
        w1 = 1; d1 = 8'h01; tick();
        chk("fw_first", q1, 8'h01);
        d1 = 8'h02; tick();
        d1 = 8'h03; tick(); w1 = 0;
        chk("fw_hold", q1, 8'h01); chk("fw_cnt3", cnt1, 3);
        r1 = 1; tick();
        chk("fw_adv2", q1, 8'h02); chk("fw_cnt2", cnt1, 2);
        w1 = 1; d1 = 8'h04; tick();
        chk("fw_adv3", q1, 8'h03); chk("fw_cnt2b", cnt1, 2);
        w1 = 0; tick();
        chk("fw_adv4", q1, 8'h04); chk("fw_cnt1", cnt1, 1);
        w1 = 1; d1 = 8'h05; tick();
        chk("fw_bypass", q1, 8'h05); chk("fw_bypass_cnt", cnt1, 1); chk("fw_bypass_v", v1, 1);
        w1 = 0; tick(); r1 = 0;
        chk("fw_end_v", v1, 0); chk("fw_end_empty", emp1, 1);

        // asynchronous reset mid-stream
        w0 = 1;
        for (int i = 0; i < 7; i++) begin
            d0 = 8'(8'h30 + i);
            tick();
        end
        w0 = 0;
        chk("pre_rst_cnt", cnt0, 7);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_cnt", cnt0, 0); chk("mid_rst_empty", emp0, 1); chk("mid_rst_full", full0, 0);
        chk("mid_rst_pe", pe0, 1); chk("mid_rst_v", v0, 0); chk("mid_rst_dout", q0, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        w0 = 1; d0 = 8'h77; tick(); w0 = 0;
        r0 = 1; tick(); r0 = 0;
        chk("post_rst_d", q0, 8'h77); chk("post_rst_v", v0, 1);
        tick();
        chk("post_rst_empty", emp0, 1); chk("post_rst_cnt", cnt0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
